door_lock_core: RTL and testbench
=================================

# door_lock_core

Parametrised successor to the fixed 3-digit door-lock controller: the FSM core behind the board wrapper, with configurable PIN length, trial budget and auto-relock time. It also adds an in-field PIN change with confirm step and a timed lockout. It sits between the debounced key/switch front end (one-cycle pulses) and the 7-segment/LED display drivers, and exposes registered status only.

## Interface

- PIN_DIGITS, 4, PIN length in BCD digits (1..8)
- MAX_TRIALS, 3, failed submits allowed before lockout (1..15)
- UNLOCK_CYCLES, 250_000_000, cycles OPEN is held before auto-relock (≥2)
- LOCKOUT_CYCLES, 500_000_000, lockout duration in cycles (used only with DOOR_LOCK_LOCKOUT_TIMER_EN)
- DEFAULT_PIN, 32'h0000_1234, reset PIN; low 4*PIN_DIGITS bits used, digit 0 newest at LSB nibble

- i_clk  in  1  system clock (50 MHz on board)
- i_hard_reset_n  in  1  one clock; reset is synchronous and active-low
- i_digit  in  4  BCD digit; values >9 ignored
- i_digit_valid  in  1  one-cycle pulse: accept i_digit
- i_submit  in  1  one-cycle pulse: submit entry / relock when OPEN
- i_change  in  1  one-cycle pulse: begin PIN change (OPEN only)
- i_clear  in  1  one-cycle pulse: discard current entry
- o_state  out  3  LOCKED=0, OPEN=1, NEW_PIN=2, CONFIRM_PIN=3, LOCKOUT=4
- o_unlocked  out  1  high in OPEN
- o_incorrect  out  1  failed-submit flag
- o_locked_out  out  1  high in LOCKOUT
- o_trials_left  out  4  remaining trials
- o_entry  out  4*PIN_DIGITS  entered digits, newest at LSB nibble
- o_entry_count  out  4  digits entered (0..PIN_DIGITS)

## Operation

- Reset (i_hard_reset_n=0 at posedge): state LOCKED, PIN=DEFAULT_PIN, trials=MAX_TRIALS, entry=0, count=0, o_incorrect=0, timers=0. Reset wins over every input, in any state.
- Entry buffer (LOCKED, NEW_PIN, CONFIRM_PIN): valid digit shifts in at LSB and increments count. Digits beyond PIN_DIGITS and non-BCD digits are dropped with no state change.
- Same-cycle priority: i_clear > i_submit > i_digit_valid; lower-priority events are dropped. In OPEN: i_submit > i_change.
- LOCKED, submit:
  - count==PIN_DIGITS and entry==PIN -> OPEN; trials=MAX_TRIALS; o_incorrect=0.
  - Otherwise, including a short entry -> trials-1 and o_incorrect=1. Trials reaching 0 -> LOCKOUT, else stay LOCKED.
  - Entry is cleared in both cases.
- o_incorrect clears on the next accepted digit, on i_clear, or on a successful unlock.
- OPEN: digits ignored; unlock timer runs. i_submit, or the timer reaching UNLOCK_CYCLES-1 -> LOCKED. i_change -> NEW_PIN with entry cleared.
- NEW_PIN: a full submit latches the candidate and moves to CONFIRM_PIN. A short submit is ignored.
- CONFIRM_PIN: full submit with entry==candidate -> PIN updated, go to OPEN. Mismatch or short submit -> OPEN, PIN unchanged, o_incorrect=1. Entering OPEN always restarts the unlock timer.
- LOCKOUT: all inputs ignored; entry held at 0.

## Timing

- All outputs registered; each effect appears on the clock edge after the sampled pulse (latency 1).
- o_unlocked is high for exactly UNLOCK_CYCLES cycles per OPEN entry absent i_submit/i_change.
- Counters saturate and do not wrap. o_trials_left never underflows below 0.
- Reset asserted mid-change discards the candidate. The PIN returns to DEFAULT_PIN.

## Configuration

- DOOR_LOCK_LOCKOUT_TIMER_EN defined: LOCKOUT counts LOCKOUT_CYCLES cycles, then goes to LOCKED with trials=MAX_TRIALS and o_incorrect=0.
- Undefined: LOCKOUT is permanent until i_hard_reset_n. No lockout counter is synthesised.

## Test plan

- PIN_DIGITS=4, default PIN, digits 1,2,3,4 then submit -> next cycle o_state=1, o_unlocked=1, o_trials_left=3.
- Digits 1,2,3,5 + submit three times -> trials 2,1,0, then o_state=4, o_locked_out=1. With the macro, after LOCKOUT_CYCLES -> o_state=0, trials=3. Without it, the state holds until reset.
- Unlock, then idle -> o_unlocked falls after exactly UNLOCK_CYCLES cycles. i_submit mid-window -> relock next cycle.
- Unlock, i_change, enter 9,8,7,6 + submit, enter 9,8,7,6 + submit -> OPEN. Relock, then 9,8,7,6 unlocks and 1,2,3,4 fails.
- Confirm with mismatched 9,8,7,0 -> OPEN, o_incorrect=1, PIN still 1234.
- i_clear and i_submit in the same cycle -> entry cleared, no trial consumed. Five digits entered -> o_entry_count=4, 5th digit dropped. Reset pulse in CONFIRM_PIN -> LOCKED, default PIN.

Source files
------------

// File: rtl/door_lock_core.sv
// door_lock_core
//
// FSM core of the keypad door lock. Collects BCD digits into an entry buffer,
// compares a full entry against the stored PIN on submit, counts failed
// attempts down to a lockout, holds the door open for a fixed window, and
// supports changing the PIN from the OPEN state with a confirm step.
//
// Build option:
//   DOOR_LOCK_LOCKOUT_TIMER_EN  defined   -> LOCKOUT ends after LOCKOUT_CYCLES
//                               undefined -> LOCKOUT holds until reset
//
// Ports:
//   i_clk, i_hard_reset_n         clock, synchronous active-low reset
//   i_digit, i_digit_valid        BCD digit pulse (values > 9 are ignored)
//   i_submit, i_change, i_clear   one-cycle command pulses
//   o_state                       LOCKED=0 OPEN=1 NEW_PIN=2 CONFIRM_PIN=3 LOCKOUT=4
//   o_unlocked, o_locked_out      state decodes (registered)
//   o_incorrect                   last submit failed
//   o_trials_left                 remaining attempts before lockout
//   o_entry, o_entry_count        entry buffer (newest digit in LSB nibble)
//
// State table:
//   state         | meaning
//   S_LOCKED      | door locked, collecting a PIN attempt
//   S_OPEN        | door open, unlock window counting down
//   S_NEW_PIN     | collecting a candidate PIN
//   S_CONFIRM_PIN | collecting the candidate again for confirmation
//   S_LOCKOUT     | trial budget exhausted, inputs ignored

module door_lock_core #(
    parameter int          PIN_DIGITS     = 4,
    parameter int          MAX_TRIALS     = 3,
    parameter int          UNLOCK_CYCLES  = 250_000_000,
    parameter int          LOCKOUT_CYCLES = 500_000_000,
    parameter logic [31:0] DEFAULT_PIN    = 32'h0000_1234
) (
    input  logic                    i_clk,
    input  logic                    i_hard_reset_n,
    input  logic [3:0]              i_digit,
    input  logic                    i_digit_valid,
    input  logic                    i_submit,
    input  logic                    i_change,
    input  logic                    i_clear,
    output logic [2:0]              o_state,
    output logic                    o_unlocked,
    output logic                    o_incorrect,
    output logic                    o_locked_out,
    output logic [3:0]              o_trials_left,
    output logic [4*PIN_DIGITS-1:0] o_entry,
    output logic [3:0]              o_entry_count
);

    localparam int EW   = 4 * PIN_DIGITS;
    localparam int UT_W = (UNLOCK_CYCLES > 2) ? $clog2(UNLOCK_CYCLES) : 1;

    if (PIN_DIGITS < 1 || PIN_DIGITS > 8 || MAX_TRIALS < 1 || MAX_TRIALS > 15 ||
        UNLOCK_CYCLES < 2 || LOCKOUT_CYCLES < 2) begin : g_bad_cfg
        $error("door_lock_core: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_LOCKED      = 3'd0,
        S_OPEN        = 3'd1,
        S_NEW_PIN     = 3'd2,
        S_CONFIRM_PIN = 3'd3,
        S_LOCKOUT     = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [EW-1:0]     pin_q, pin_d;
    logic [EW-1:0]     cand_q, cand_d;
    logic [EW-1:0]     entry_q, entry_d;
    logic [3:0]        count_q, count_d;
    logic [3:0]        trials_q, trials_d;
    logic              incorrect_q, incorrect_d;
    logic [UT_W-1:0]   utmr_q, utmr_d;
    logic              unlocked_q, locked_out_q;

`ifdef DOOR_LOCK_LOCKOUT_TIMER_EN
    localparam int LT_W = (LOCKOUT_CYCLES > 2) ? $clog2(LOCKOUT_CYCLES) : 1;
    logic [LT_W-1:0]   ltmr_q, ltmr_d;
`endif

    logic              full;
    logic              digit_ok;
    logic              entry_state;
    logic [EW-1:0]     entry_shift;
    logic [3:0]        trials_dec;

    always_comb begin
        state_d     = state_q;
        pin_d       = pin_q;
        cand_d      = cand_q;
        entry_d     = entry_q;
        count_d     = count_q;
        trials_d    = trials_q;
        incorrect_d = incorrect_q;
        utmr_d      = utmr_q;
`ifdef DOOR_LOCK_LOCKOUT_TIMER_EN
        ltmr_d      = ltmr_q;
`endif

        full        = (count_q == 4'(PIN_DIGITS));
        digit_ok    = i_digit_valid && (i_digit <= 4'd9) && !full;
        entry_shift = EW'({entry_q, i_digit});
        trials_dec  = (trials_q == 4'd0) ? 4'd0 : trials_q - 4'd1;
        entry_state = (state_q == S_LOCKED) || (state_q == S_NEW_PIN) ||
                      (state_q == S_CONFIRM_PIN);

        // Clear beats submit beats digit in every entry-collecting state.
        if (entry_state) begin
            if (i_clear) begin
                entry_d     = '0;
                count_d     = 4'd0;
                incorrect_d = 1'b0;
            end else if (!i_submit && digit_ok) begin
                entry_d     = entry_shift;
                count_d     = count_q + 4'd1;
                incorrect_d = 1'b0;
            end
        end

        case (state_q)
            S_LOCKED: begin
                if (!i_clear && i_submit) begin
                    entry_d = '0;
                    count_d = 4'd0;
                    if (full && entry_q == pin_q) begin
                        state_d     = S_OPEN;
                        trials_d    = 4'(MAX_TRIALS);
                        incorrect_d = 1'b0;
                        utmr_d      = UT_W'(UNLOCK_CYCLES - 1);
                    end else begin
                        trials_d    = trials_dec;
                        incorrect_d = 1'b1;
                        if (trials_dec == 4'd0) begin
                            state_d = S_LOCKOUT;
`ifdef DOOR_LOCK_LOCKOUT_TIMER_EN
                            ltmr_d  = LT_W'(LOCKOUT_CYCLES - 1);
`endif
                        end
                    end
                end
            end
            S_OPEN: begin
                // Timer expiry wins over a change request in the same cycle.
                if (i_submit || utmr_q == '0) begin
                    state_d = S_LOCKED;
                end else begin
                    utmr_d = utmr_q - 1'b1;
                    if (i_change) begin
                        state_d = S_NEW_PIN;
                        entry_d = '0;
                        count_d = 4'd0;
                    end
                end
            end
            S_NEW_PIN: begin
                if (!i_clear && i_submit && full) begin
                    cand_d  = entry_q;
                    entry_d = '0;
                    count_d = 4'd0;
                    state_d = S_CONFIRM_PIN;
                end
            end
            S_CONFIRM_PIN: begin
                if (!i_clear && i_submit) begin
                    entry_d = '0;
                    count_d = 4'd0;
                    state_d = S_OPEN;
                    utmr_d  = UT_W'(UNLOCK_CYCLES - 1);
                    if (full && entry_q == cand_q) begin
                        pin_d = cand_q;
                    end else begin
                        incorrect_d = 1'b1;
                    end
                end
            end
            S_LOCKOUT: begin
                entry_d = '0;
                count_d = 4'd0;
`ifdef DOOR_LOCK_LOCKOUT_TIMER_EN
                if (ltmr_q == '0) begin
                    state_d     = S_LOCKED;
                    trials_d    = 4'(MAX_TRIALS);
                    incorrect_d = 1'b0;
                end else begin
                    ltmr_d = ltmr_q - 1'b1;
                end
`endif
            end
            default: begin
                state_d = S_LOCKED;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_hard_reset_n) begin
            state_q      <= S_LOCKED;
            pin_q        <= DEFAULT_PIN[EW-1:0];
            cand_q       <= '0;
            entry_q      <= '0;
            count_q      <= 4'd0;
            trials_q     <= 4'(MAX_TRIALS);
            incorrect_q  <= 1'b0;
            utmr_q       <= '0;
            unlocked_q   <= 1'b0;
            locked_out_q <= 1'b0;
`ifdef DOOR_LOCK_LOCKOUT_TIMER_EN
            ltmr_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            pin_q        <= pin_d;
            cand_q       <= cand_d;
            entry_q      <= entry_d;
            count_q      <= count_d;
            trials_q     <= trials_d;
            incorrect_q  <= incorrect_d;
            utmr_q       <= utmr_d;
            unlocked_q   <= (state_d == S_OPEN);
            locked_out_q <= (state_d == S_LOCKOUT);
`ifdef DOOR_LOCK_LOCKOUT_TIMER_EN
            ltmr_q       <= ltmr_d;
`endif
        end
    end

    assign o_state       = state_q;
    assign o_unlocked    = unlocked_q;
    assign o_locked_out  = locked_out_q;
    assign o_incorrect   = incorrect_q;
    assign o_trials_left = trials_q;
    assign o_entry       = entry_q;
    assign o_entry_count = count_q;

endmodule

// File: tb/tb_door_lock_core.sv
// Scoreboard bench for door_lock_core: the driver pushes the expected status
// for the cycle after each stimulus; the monitor pops and compares.

module tb_door_lock_core;

    localparam int UNL = 8;
    localparam int LCK = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  digit = 4'd0;
    logic        dv = 1'b0, sub = 1'b0, chg = 1'b0, clr = 1'b0;
    logic [2:0]  st;
    logic        unl, inc, lo;
    logic [3:0]  tr, cn;
    logic [15:0] en;

    door_lock_core #(
        .PIN_DIGITS(4), .MAX_TRIALS(3), .UNLOCK_CYCLES(UNL),
        .LOCKOUT_CYCLES(LCK), .DEFAULT_PIN(32'h0000_1234)
    ) dut (
        .i_clk(clk), .i_hard_reset_n(rst_n), .i_digit(digit),
        .i_digit_valid(dv), .i_submit(sub), .i_change(chg), .i_clear(clr),
        .o_state(st), .o_unlocked(unl), .o_incorrect(inc),
        .o_locked_out(lo), .o_trials_left(tr), .o_entry(en),
        .o_entry_count(cn)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        int          cyc;
        logic [2:0]  st;
        logic        inc;
        logic [3:0]  tr;
        logic [15:0] en;
        logic [3:0]  cn;
    } exp_t;

    exp_t  q[$];
    string nq[$];
    int    n_vec = 0;
    int    n_bad = 0;

    task automatic put_at(input string nm, input int c, input logic [2:0] s,
                          input logic i, input logic [3:0] t,
                          input logic [15:0] e, input logic [3:0] n);
        exp_t x;
        x.cyc = c; x.st = s; x.inc = i; x.tr = t; x.en = e; x.cn = n;
        q.push_back(x);
        nq.push_back(nm);
    endtask

    task automatic put(input string nm, input logic [2:0] s, input logic i,
                       input logic [3:0] t, input logic [15:0] e,
                       input logic [3:0] n);
        put_at(nm, cycle + 1, s, i, t, e, n);
    endtask

    task automatic drv(input logic r, input logic v, input logic [3:0] d,
                       input logic s, input logic c, input logic cl);
        @(negedge clk);
        rst_n = r; dv = v; digit = d; sub = s; chg = c; clr = cl;
    endtask

    task automatic key(input logic [3:0] d); drv(1, 1, d, 0, 0, 0); endtask
    task automatic submit();                 drv(1, 0, 0, 1, 0, 0); endtask
    task automatic change();                 drv(1, 0, 0, 0, 1, 0); endtask
    task automatic clear();                  drv(1, 0, 0, 0, 0, 1); endtask
    task automatic idle();                   drv(1, 0, 0, 0, 0, 0); endtask
    task automatic rst();                    drv(0, 0, 0, 0, 0, 0); endtask

    task automatic enter4(input string nm, input logic [15:0] pin,
                          input logic [2:0] s, input logic [3:0] t);
        logic [15:0] e;
        e = 16'h0;
        for (int i = 0; i < 4; i++) begin
            logic [3:0] d;
            d = pin[15 - 4*i -: 4];
            key(d);
            e = {e[11:0], d};
            put($sformatf("%s_d%0d", nm, i), s, 1'b0, t, e, 4'(i + 1));
        end
    endtask

    // Monitor: status is presented every cycle; compare whatever is due.
    exp_t  m_e;
    string m_n;
    always @(posedge clk) begin
        #1;
        while (q.size() > 0 && q[0].cyc <= cycle) begin
            m_e = q.pop_front();
            m_n = nq.pop_front();
            n_vec++;
            if (m_e.cyc < cycle) begin
                n_bad++;
                $display("FAIL %s: not sampled at cycle %0d (now %0d)", m_n, m_e.cyc, cycle);
            end else if (st !== m_e.st || unl !== (m_e.st == 3'd1) ||
                         lo !== (m_e.st == 3'd4) || inc !== m_e.inc ||
                         tr !== m_e.tr || en !== m_e.en || cn !== m_e.cn) begin
                n_bad++;
                $display("FAIL %s @%0d: got st=%0d unl=%b lo=%b inc=%b tr=%0d en=%h cn=%0d, want st=%0d inc=%b tr=%0d en=%h cn=%0d",
                         m_n, cycle, st, unl, lo, inc, tr, en, cn,
                         m_e.st, m_e.inc, m_e.tr, m_e.en, m_e.cn);
            end
        end
    end

    int c_open;
    int c_lock;

    initial begin
        rst();  put("reset", 0, 0, 3, 16'h0, 0);

        // Entry buffer limits and priority
        enter4("e", 16'h1234, 0, 3);
        key(4'd5);    put("fifth_dropped", 0, 0, 3, 16'h1234, 4);
        key(4'hC);    put("nonbcd_full", 0, 0, 3, 16'h1234, 4);
        clear();      put("clear", 0, 0, 3, 16'h0, 0);
        key(4'hA);    put("nonbcd_dropped", 0, 0, 3, 16'h0, 0);
        key(4'd1);    put("one_digit", 0, 0, 3, 16'h0001, 1);
        drv(1, 0, 0, 1, 0, 1); put("clear_over_submit", 0, 0, 3, 16'h0, 0);

        // Unlock (submit beats digit), then auto-relock after UNL cycles
        enter4("u", 16'h1234, 0, 3);
        drv(1, 1, 4'd5, 1, 0, 0); put("unlock", 1, 0, 3, 16'h0, 0);
        c_open = cycle + 1;
        key(4'd7);    put("open_digit_ignored", 1, 0, 3, 16'h0, 0);
        put_at("open_last_cycle", c_open + UNL - 1, 1, 0, 3, 16'h0, 0);
        put_at("auto_relock", c_open + UNL, 0, 0, 3, 16'h0, 0);
        repeat (UNL) idle();

        // Manual relock
        enter4("m", 16'h1234, 0, 3);
        submit();     put("unlock2", 1, 0, 3, 16'h0, 0);
        idle(); idle();
        submit();     put("manual_relock", 0, 0, 3, 16'h0, 0);

        // Failed trials down to lockout
        enter4("w1", 16'h1235, 0, 3);
        submit();     put("fail1", 0, 1, 2, 16'h0, 0);
        enter4("w2", 16'h1235, 0, 2);
        submit();     put("fail2", 0, 1, 1, 16'h0, 0);
        key(4'd1);    put("short_digit", 0, 0, 1, 16'h0001, 1);
        submit();     put("fail3_short_lockout", 4, 1, 0, 16'h0, 0);
        c_lock = cycle + 1;
        key(4'd1);    put("lockout_digit", 4, 1, 0, 16'h0, 0);
        clear();      put("lockout_clear", 4, 1, 0, 16'h0, 0);
`ifdef DOOR_LOCK_LOCKOUT_TIMER_EN
        put_at("lockout_last", c_lock + LCK - 1, 4, 1, 0, 16'h0, 0);
        put_at("lockout_end", c_lock + LCK, 0, 0, 3, 16'h0, 0);
        repeat (LCK) idle();
`else
        repeat (20) idle();
        idle();       put("lockout_hold", 4, 1, 0, 16'h0, 0);
`endif
        rst();        put("reset2", 0, 0, 3, 16'h0, 0);

        // PIN change to 9876
        enter4("c0", 16'h1234, 0, 3);
        submit();     put("c_unlock", 1, 0, 3, 16'h0, 0);
        change();     put("to_new_pin", 2, 0, 3, 16'h0, 0);
        key(4'd9);    put("n9", 2, 0, 3, 16'h0009, 1);
        key(4'd8);    put("n8", 2, 0, 3, 16'h0098, 2);
        submit();     put("new_short_ignored", 2, 0, 3, 16'h0098, 2);
        key(4'd7);    put("n7", 2, 0, 3, 16'h0987, 3);
        key(4'd6);    put("n6", 2, 0, 3, 16'h9876, 4);
        submit();     put("to_confirm", 3, 0, 3, 16'h0, 0);
        enter4("cf", 16'h9876, 3, 3);
        submit();     put("commit", 1, 0, 3, 16'h0, 0);
        submit();     put("relock_a", 0, 0, 3, 16'h0, 0);
        enter4("np", 16'h9876, 0, 3);
        submit();     put("new_pin_opens", 1, 0, 3, 16'h0, 0);
        submit();     put("relock_b", 0, 0, 3, 16'h0, 0);
        enter4("op", 16'h1234, 0, 3);
        submit();     put("old_pin_fails", 0, 1, 2, 16'h0, 0);
        rst();        put("reset3", 0, 0, 3, 16'h0, 0);
        enter4("dp", 16'h1234, 0, 3);
        submit();     put("default_after_reset", 1, 0, 3, 16'h0, 0);

        // Confirm mismatch keeps old PIN
        change();     put("mm_new", 2, 0, 3, 16'h0, 0);
        enter4("mn", 16'h9876, 2, 3);
        submit();     put("mm_confirm", 3, 0, 3, 16'h0, 0);
        enter4("mc", 16'h9870, 3, 3);
        submit();     put("mismatch", 1, 1, 3, 16'h0, 0);
        submit();     put("relock_inc_held", 0, 1, 3, 16'h0, 0);
        enter4("mu", 16'h1234, 0, 3);
        submit();     put("pin_unchanged", 1, 0, 3, 16'h0, 0);

        // Reset during confirm discards the candidate
        change();     put("rc_new", 2, 0, 3, 16'h0, 0);
        enter4("rn", 16'h9876, 2, 3);
        submit();     put("rc_confirm", 3, 0, 3, 16'h0, 0);
        key(4'd9);    put("rc_digit", 3, 0, 3, 16'h0009, 1);
        rst();        put("reset_in_confirm", 0, 0, 3, 16'h0, 0);
        enter4("rx", 16'h9876, 0, 3);
        submit();     put("cand_discarded", 0, 1, 2, 16'h0, 0);
        enter4("rd", 16'h1234, 0, 2);
        submit();     put("default_pin", 1, 0, 3, 16'h0, 0);

        // Submit beats change in OPEN
        drv(1, 0, 0, 1, 1, 0); put("submit_over_change", 0, 0, 3, 16'h0, 0);

        for (int i = 0; i < 40 && q.size() > 0; i++) idle();
        while (q.size() > 0) begin
            m_e = q.pop_front();
            m_n = nq.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL %s: expectation for cycle %0d never checked", m_n, m_e.cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
